alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Upstream input stage for the mini ALU.
- Turns one 4-bit switch bank and two active-low push-buttons into stable, registered operands and mode bits.
- Its outputs drive the ALU's op1, op2, operation and sign inputs directly.
- Contains per-button synchronisation and debounce, plus a 4-state entry FSM, so the user loads op1, op2 and mode one button press at a time.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised samples required before a button level change is accepted (5 ms at 50 MHz). Minimum 2.
- SYNC_STAGES, 2: flip-flops in each button synchroniser. Minimum 2.

Ports:
- clk  input  1  system clock; all state on the rising edge
- rst  input  1  reset, asynchronous, active-high
- sw  input  4  raw switch value, sampled only on a latch event
- key_next_n  input  1  raw "next" button, active-low, asynchronous to clk
- key_clear_n  input  1  raw "clear" button, active-low, asynchronous to clk
- op1  output  4  registered first operand to ALU
- op2  output  4  registered second operand to ALU
- operation  output  1  registered ALU operation select (1 = shift, 0 = add/sub)
- sign  output  1  registered ALU sign/direction select
- valid  output  1  high when all three fields are loaded (state HOLD)
- stage  output  2  current FSM state encoding, for LEDs

Behaviour:
Reset (async, active-high):
- op1 = 0, op2 = 0, operation = 0, sign = 0, valid = 0, stage = 0 (LOAD_OP1).
- Synchroniser flops are set to 1 (released); debounced levels are 1; debounce counters are 0.
- Reset asserted mid-entry discards all partial entry.

Button conditioning (identical, independent per button):
- SYNC_STAGES flop chain produces the synchronised level s.
- Debounced level d and counter cnt:
  - if s == d: cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1: d <= s and cnt <= 0;
  - else cnt <= cnt+1.
- cnt width is clog2(DEBOUNCE_CYCLES).
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes d.
- A press event is a one-cycle pulse, registered, asserted the cycle after d goes 1 -> 0.
- Release generates no event.
- Holding the button produces exactly one event.

Latency:
- Raw input held low from edge 0 gives the press pulse high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- The target register updates on the following edge.

FSM states (stage encoding):
- LOAD_OP1 (0): on next event, op1 <= sw; go to LOAD_OP2.
- LOAD_OP2 (1): on next event, op2 <= sw; go to LOAD_MODE.
- LOAD_MODE (2): on next event, operation <= sw[1], sign <= sw[0]; go to HOLD.
- HOLD (3): valid = 1. On next event, go to LOAD_OP1 with valid <= 0. op1, op2, operation and sign keep their values until individually overwritten.

Clear event:
- In any state: op1, op2, operation, sign <= 0; valid <= 0; go to LOAD_OP1.

Output and event rules:
- Simultaneous next and clear events in the same cycle: clear wins; next is dropped.
- valid is registered and equals (state == HOLD).
- Outputs never change except on an event or reset.
- Switch changes with no event have no effect.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Reset then idle: all outputs 0, stage=0. Pulse rst mid-sequence (stage=2, op1=5) -> same values immediately, without waiting for a clock edge.
2. Full entry: sw=4'h9 + next press, sw=4'h3 + press, sw=4'b0011 + press -> op1=9, op2=3, operation=1, sign=1, valid=1, stage=3. Each update lands exactly 8 edges after key_next_n falls.
3. Bounce: key_next_n toggled low/high every 2 cycles for 20 cycles, then held low -> exactly one latch event. No event during the bouncing window.
4. Long hold: key_next_n low for 100 cycles in LOAD_OP1 -> single advance to stage=1. Release then press again -> stage=2.
5. Clear: from HOLD with op1=9, press clear -> all fields 0, valid=0, stage=0. Next and clear events forced in the same cycle in stage=1 -> result stage=0, op2 unchanged at 0.
6. Wrap: in HOLD press next with sw=4'hF -> stage=0, valid=0, op1 still 9. Next press -> op1=F.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Front end for the mini ALU. It conditions two raw active-low push-buttons
//   and lets the user load op1, op2 and the mode bits one "next" press at a
//   time from a 4-bit switch bank. A "clear" press wipes the entry.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sw[3:0]      raw switch value, sampled only when a next press is taken
//   key_next_n   raw "next" button, active-low, asynchronous to clk
//   key_clear_n  raw "clear" button, active-low, asynchronous to clk
//   op1[3:0]     registered first operand
//   op2[3:0]     registered second operand
//   operation    registered operation select (1 = shift, 0 = add/sub)
//   sign         registered sign/direction select
//   valid        high while all three fields are loaded (HOLD)
//   stage[1:0]   current entry state, for LEDs

// alu_operand_btn_cond
//   One button conditioner: synchroniser chain, debounce counter, and a
//   one-cycle registered pulse on each accepted press (debounced 1 -> 0).
//
// Ports
//   clk, rst     as above
//   key_n        raw active-low button
//   press        one-cycle pulse, the cycle after the debounced level falls
module alu_operand_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic                   level;
    logic                   level_dly;
    logic [CNT_W-1:0]       cnt;

    assign synced = sync[SYNC_STAGES-1];

    // Released (high) is the reset level everywhere, so coming out of reset
    // never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '1;
            level     <= 1'b1;
            level_dly <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], key_n};
            level_dly <= level;
            press     <= level_dly & ~level;

            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// Entry FSM
//   state     | meaning
//   LOAD_OP1  | waiting for next press to capture op1 from sw
//   LOAD_OP2  | waiting for next press to capture op2 from sw
//   LOAD_MODE | waiting for next press to capture operation=sw[1], sign=sw[0]
//   HOLD      | all fields loaded, valid high; next press restarts entry
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       key_next_n,
    input  logic       key_clear_n,
    output logic [3:0] op1,
    output logic [3:0] op2,
    output logic       operation,
    output logic       sign,
    output logic       valid,
    output logic [1:0] stage
);

    typedef enum logic [1:0] {
        LOAD_OP1  = 2'd0,
        LOAD_OP2  = 2'd1,
        LOAD_MODE = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [3:0] op1_n;
    logic [3:0] op2_n;
    logic       operation_n;
    logic       sign_n;
    logic       next_ev;
    logic       clear_ev;

    alu_operand_btn_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_next (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_next_n),
        .press (next_ev)
    );

    alu_operand_btn_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_clear (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clear_n),
        .press (clear_ev)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_OP1;
            op1       <= '0;
            op2       <= '0;
            operation <= 1'b0;
            sign      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state     <= state_n;
            op1       <= op1_n;
            op2       <= op2_n;
            operation <= operation_n;
            sign      <= sign_n;
            valid     <= (state_n == HOLD);
        end
    end

    // Clear takes priority; a next press in the same cycle is dropped.
    always_comb begin
        state_n     = state;
        op1_n       = op1;
        op2_n       = op2;
        operation_n = operation;
        sign_n      = sign;

        if (clear_ev) begin
            state_n     = LOAD_OP1;
            op1_n       = '0;
            op2_n       = '0;
            operation_n = 1'b0;
            sign_n      = 1'b0;
        end else if (next_ev) begin
            case (state)
                LOAD_OP1: begin
                    op1_n   = sw;
                    state_n = LOAD_OP2;
                end
                LOAD_OP2: begin
                    op2_n   = sw;
                    state_n = LOAD_MODE;
                end
                LOAD_MODE: begin
                    operation_n = sw[1];
                    sign_n      = sw[0];
                    state_n     = HOLD;
                end
                default: begin
                    state_n = LOAD_OP1;
                end
            endcase
        end
    end

    assign stage = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'h0;
    logic       key_next_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [3:0] op1, op2;
    logic       operation, sign, valid;
    logic [1:0] stage;

    int tests = 0;
    int fails = 0;

    // Reference model: the entry is a position 0..3 plus the stored fields.
    int         m_pos = 0;
    logic [3:0] m_op1 = 4'h0;
    logic [3:0] m_op2 = 4'h0;
    logic       m_operation = 1'b0;
    logic       m_sign = 1'b0;

    alu_operand_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .key_next_n  (key_next_n),
        .key_clear_n (key_clear_n),
        .op1         (op1),
        .op2         (op2),
        .operation   (operation),
        .sign        (sign),
        .valid       (valid),
        .stage       (stage)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".op1"}, op1, m_op1);
        check({tag, ".op2"}, op2, m_op2);
        check({tag, ".operation"}, {3'b0, operation}, {3'b0, m_operation});
        check({tag, ".sign"}, {3'b0, sign}, {3'b0, m_sign});
        check({tag, ".valid"}, {3'b0, valid}, (m_pos == 3) ? 4'h1 : 4'h0);
        check({tag, ".stage"}, {2'b0, stage}, 4'(m_pos));
    endtask

    task automatic model_reset();
        m_pos = 0; m_op1 = 0; m_op2 = 0; m_operation = 0; m_sign = 0;
    endtask

    task automatic model_event(input bit is_clear, input logic [3:0] v);
        if (is_clear) begin
            model_reset();
        end else begin
            if (m_pos == 0) m_op1 = v;
            else if (m_pos == 1) m_op2 = v;
            else if (m_pos == 2) begin
                m_operation = v[1];
                m_sign = v[0];
            end
            m_pos = (m_pos + 1) % 4;
        end
    endtask

    // Button held low for 'hold' cycles (>= 4 is a press), then released
    // long enough for the debounced level to return high.
    task automatic press(input bit is_clear, input logic [3:0] v, input int hold, input string tag);
        @(negedge clk);
        sw = v;
        if (is_clear) key_clear_n = 1'b0; else key_next_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_clear_n = 1'b1;
        key_next_n = 1'b1;
        repeat (10) @(negedge clk);
        model_event(is_clear, v);
        check_all(tag);
    endtask

    // Next press whose register update must land exactly 8 edges after the fall.
    task automatic press_timed(input logic [3:0] v, input string tag);
        @(negedge clk);
        sw = v;
        key_next_n = 1'b0;
        repeat (7) @(posedge clk);
        #1 check({tag, ".early"}, {2'b0, stage}, 4'(m_pos));
        @(posedge clk);
        #1 model_event(1'b0, v);
        check_all(tag);
        @(negedge clk);
        key_next_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int changes;
        logic [1:0] st0;

        // 1. reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        model_reset();
        check_all("reset_idle");
        press(1'b0, 4'h5, 6, "pre_op1");
        press(1'b0, 4'hA, 6, "pre_op2");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 2. full entry with exact latency
        press_timed(4'h9, "entry_op1");
        press_timed(4'h3, "entry_op2");
        press_timed(4'b0011, "entry_mode");

        // 5a. clear from HOLD
        press(1'b1, 4'h7, 6, "clear_hold");

        // 4. long hold gives one advance, then a second press advances again
        press(1'b0, 4'h9, 100, "long_hold");
        press(1'b0, 4'h2, 6, "after_long");
        press(1'b0, 4'h3, 6, "to_hold");

        // 6. wrap from HOLD keeps op1, next press overwrites it
        press(1'b0, 4'hF, 6, "wrap");
        press(1'b0, 4'hF, 6, "wrap_op1");

        // 3. bouncing: no event during the window, exactly one after
        @(negedge clk);
        sw = 4'h6;
        st0 = stage;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            key_next_n = (i % 4) >= 2;
            @(negedge clk);
            if (stage !== st0) changes++;
        end
        check("bounce_window", 4'(changes), 4'h0);
        key_next_n = 1'b0;
        repeat (12) @(negedge clk);
        key_next_n = 1'b1;
        repeat (10) @(negedge clk);
        model_event(1'b0, 4'h6);
        check_all("bounce_one_event");

        // 5b. simultaneous next and clear: clear wins
        press(1'b1, 4'h0, 6, "clear2");
        press(1'b0, 4'h4, 6, "to_op2");
        @(negedge clk);
        sw = 4'hC;
        key_next_n = 1'b0;
        key_clear_n = 1'b0;
        repeat (8) @(negedge clk);
        key_next_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (10) @(negedge clk);
        model_event(1'b1, 4'hC);
        check_all("simultaneous");

        // randomized sequence of presses, clears and glitch bursts
        for (int n = 0; n < 40; n++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act <= 5) begin
                press(1'b0, 4'($urandom_range(0, 15)), $urandom_range(4, 15), "rnd_next");
            end else if (act == 6) begin
                press(1'b1, 4'($urandom_range(0, 15)), $urandom_range(4, 10), "rnd_clear");
            end else begin
                int bursts;
                bursts = $urandom_range(1, 4);
                for (int b = 0; b < bursts; b++) begin
                    @(negedge clk);
                    sw = 4'($urandom_range(0, 15));
                    if (act == 7) key_clear_n = 1'b0; else key_next_n = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    key_next_n = 1'b1;
                    key_clear_n = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                repeat (8) @(negedge clk);
                check_all("rnd_glitch");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
